// File: rtl/sd_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_read_sequencer_if
// Brief    : Bundle between the SD read sequencer, the SD card interface and
//            the downstream pixel consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_read_sequencer_if;
    logic        start;
    logic        detect;
    logic        cmd_done;
    logic        sd_error;
    logic [63:0] header_in;
    logic [23:0] image_in;
    logic        pix_ready;

    logic        cmd0;
    logic        cmd8;
    logic        acmd41;
    logic        cmd2;
    logic        cmd3;
    logic        cmd7;
    logic        change_size;
    logic [31:0] block_size;
    logic        read;
    logic [31:0] r_address;
    logic [63:0] header_data;
    logic        header_valid;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        init_done;
    logic        seq_done;
    logic        seq_error;

    modport master (
        input  start, detect, cmd_done, sd_error, header_in, image_in, pix_ready,
        output cmd0, cmd8, acmd41, cmd2, cmd3, cmd7, change_size, block_size,
               read, r_address, header_data, header_valid, pixel_data,
               pixel_valid, init_done, seq_done, seq_error
    );

    modport slave (
        output start, detect, cmd_done, sd_error, header_in, image_in, pix_ready,
        input  cmd0, cmd8, acmd41, cmd2, cmd3, cmd7, change_size, block_size,
               read, r_address, header_data, header_valid, pixel_data,
               pixel_valid, init_done, seq_done, seq_error
    );
endinterface
`default_nettype wire

// File: rtl/sd_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_read_sequencer
// Brief    : SD card bring-up and two-phase image read (header, then pixels),
//            streaming captured data downstream with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sd_read_sequencer #(
    parameter int unsigned HEADER_BYTES   = 54,
    parameter int unsigned PIXEL_BYTES    = 3,
    parameter int unsigned NUM_PIXELS     = 16,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned ACMD41_RETRIES = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    sd_read_sequencer_if.master bus
);

    localparam int unsigned     C_RW        = $clog2(ACMD41_RETRIES + 1);
    localparam logic [C_RW-1:0] C_RETRY_MAX = C_RW'(ACMD41_RETRIES);
    localparam logic [31:0]     C_HDR_BS    = 32'(HEADER_BYTES);
    localparam logic [31:0]     C_PIX_BS    = 32'(PIXEL_BYTES);
    localparam logic [31:0]     C_NUM       = 32'(NUM_PIXELS);
    localparam logic [31:0]     C_HDR_ADDR  = 32'(BASE_ADDR);
    localparam logic [31:0]     C_PIX_ADDR  = 32'(BASE_ADDR) + 32'(HEADER_BYTES);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_CMD0    = 4'd1;
    localparam logic [3:0] S_CMD8    = 4'd2;
    localparam logic [3:0] S_ACMD41  = 4'd3;
    localparam logic [3:0] S_CMD2    = 4'd4;
    localparam logic [3:0] S_CMD3    = 4'd5;
    localparam logic [3:0] S_CMD7    = 4'd6;
    localparam logic [3:0] S_SET_HDR = 4'd7;
    localparam logic [3:0] S_RD_HDR  = 4'd8;
    localparam logic [3:0] S_SET_PIX = 4'd9;
    localparam logic [3:0] S_RD_PIX  = 4'd10;
    localparam logic [3:0] S_PIX_OUT = 4'd11;
    localparam logic [3:0] S_DONE    = 4'd12;
    localparam logic [3:0] S_ERROR   = 4'd13;

    logic [3:0]      state_q,        state_d;
    logic [C_RW-1:0] retry_q,        retry_d;
    logic            gap_q,          gap_d;
    logic [31:0]     pix_cnt_q,      pix_cnt_d;
    logic [31:0]     pix_off_q,      pix_off_d;
    logic            init_done_q,    init_done_d;
    logic [63:0]     header_data_q,  header_data_d;
    logic            header_valid_q, header_valid_d;
    logic [23:0]     pixel_data_q,   pixel_data_d;

    logic            w_idle_like;
    logic            w_req_active;
    logic            w_cmd_ok;
    logic            w_cmd_err;
    logic [C_RW-1:0] w_retry_inc;
    logic [31:0]     w_cnt_inc;
    logic [31:0]     w_block_size;
    logic [31:0]     w_r_address;

    assign w_idle_like  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
    // A request is live in CMD0..RD_PIX, except the single ACMD41 retry gap cycle.
    assign w_req_active = (state_q >= S_CMD0) && (state_q <= S_RD_PIX) && !gap_q;
    assign w_cmd_ok     = bus.cmd_done && w_req_active && !bus.sd_error;
    assign w_cmd_err    = bus.cmd_done && w_req_active &&  bus.sd_error;
    assign w_retry_inc  = retry_q + C_RW'(1);
    assign w_cnt_inc    = pix_cnt_q + 32'd1;

    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        gap_d          = 1'b0;
        pix_cnt_d      = pix_cnt_q;
        pix_off_d      = pix_off_q;
        init_done_d    = init_done_q;
        header_data_d  = header_data_q;
        header_valid_d = 1'b0;
        pixel_data_d   = pixel_data_q;

        if (w_idle_like) begin
            if (bus.start) begin
                state_d     = S_CMD0;
                init_done_d = 1'b0;
                retry_d     = '0;
                pix_cnt_d   = '0;
                pix_off_d   = '0;
            end
        end else if (!bus.detect) begin
            state_d = S_ERROR;
        end else if (w_cmd_err) begin
            if (state_q == S_ACMD41) begin
                retry_d = w_retry_inc;
                if (w_retry_inc == C_RETRY_MAX) begin
                    state_d = S_ERROR;
                end else begin
                    gap_d = 1'b1;
                end
            end else begin
                state_d = S_ERROR;
            end
        end else if (w_cmd_ok) begin
            case (state_q)
                S_CMD0:    state_d = S_CMD8;
                S_CMD8:    state_d = S_ACMD41;
                S_ACMD41:  state_d = S_CMD2;
                S_CMD2:    state_d = S_CMD3;
                S_CMD3:    state_d = S_CMD7;
                S_CMD7: begin
                    state_d     = S_SET_HDR;
                    init_done_d = 1'b1;
                end
                S_SET_HDR: state_d = S_RD_HDR;
                S_RD_HDR: begin
                    header_data_d  = bus.header_in;
                    header_valid_d = 1'b1;
                    state_d        = S_SET_PIX;
                end
                S_SET_PIX: state_d = S_RD_PIX;
                S_RD_PIX: begin
                    pixel_data_d = bus.image_in;
                    state_d      = S_PIX_OUT;
                end
                default:   state_d = state_q;
            endcase
        end else if ((state_q == S_PIX_OUT) && bus.pix_ready) begin
            pix_cnt_d = w_cnt_inc;
            pix_off_d = pix_off_q + C_PIX_BS;
            state_d   = (w_cnt_inc == C_NUM) ? S_DONE : S_RD_PIX;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= S_IDLE;
            retry_q        <= '0;
            gap_q          <= 1'b0;
            pix_cnt_q      <= '0;
            pix_off_q      <= '0;
            init_done_q    <= 1'b0;
            header_data_q  <= '0;
            header_valid_q <= 1'b0;
            pixel_data_q   <= '0;
        end else begin
            state_q        <= state_d;
            retry_q        <= retry_d;
            gap_q          <= gap_d;
            pix_cnt_q      <= pix_cnt_d;
            pix_off_q      <= pix_off_d;
            init_done_q    <= init_done_d;
            header_data_q  <= header_data_d;
            header_valid_q <= header_valid_d;
            pixel_data_q   <= pixel_data_d;
        end
    end

    always_comb begin
        case (state_q)
            S_SET_HDR, S_RD_HDR:                   w_block_size = C_HDR_BS;
            S_SET_PIX, S_RD_PIX, S_PIX_OUT, S_DONE: w_block_size = C_PIX_BS;
            default:                               w_block_size = 32'd0;
        endcase
    end

    // Pixel address tracks a running offset so no multiplier is needed.
    always_comb begin
        case (state_q)
            S_RD_HDR: w_r_address = C_HDR_ADDR;
            S_RD_PIX: w_r_address = C_PIX_ADDR + pix_off_q;
            default:  w_r_address = 32'd0;
        endcase
    end

    assign bus.cmd0         = (state_q == S_CMD0);
    assign bus.cmd8         = (state_q == S_CMD8);
    assign bus.acmd41       = (state_q == S_ACMD41) && !gap_q;
    assign bus.cmd2         = (state_q == S_CMD2);
    assign bus.cmd3         = (state_q == S_CMD3);
    assign bus.cmd7         = (state_q == S_CMD7);
    assign bus.change_size  = (state_q == S_SET_HDR) || (state_q == S_SET_PIX);
    assign bus.read         = (state_q == S_RD_HDR) || (state_q == S_RD_PIX);
    assign bus.block_size   = w_block_size;
    assign bus.r_address    = w_r_address;
    assign bus.header_data  = header_data_q;
    assign bus.header_valid = header_valid_q;
    assign bus.pixel_data   = pixel_data_q;
    assign bus.pixel_valid  = (state_q == S_PIX_OUT);
    assign bus.init_done    = init_done_q;
    assign bus.seq_done     = (state_q == S_DONE);
    assign bus.seq_error    = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: doc/sd_read_sequencer.md
Name: sd_read_sequencer

Overview:
- Upstream controller for the SD card interface. Issues the card bring-up command sequence CMD0, CMD8, ACMD41, CMD2, CMD3, CMD7.
- Then reads the image in two phases:
  - sets block size to 54 and reads the BMP header;
  - sets block size to 3 and reads one 24-bit pixel per read.
- Streams captured header and pixels downstream to the Sobel datapath with a valid/ready handshake.

Parameters:
- HEADER_BYTES, 54, block size for the header read; pixel base offset.
- PIXEL_BYTES, 3, block size per pixel read; address stride.
- NUM_PIXELS, 16, pixel reads per image (1..2^32-1).
- BASE_ADDR, 0, card byte address of the header.
- ACMD41_RETRIES, 8, ACMD41 attempts allowed before declaring error.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin sequence; sampled in IDLE, DONE, ERROR
- detect  input  1  card present from interface
- cmd_done  input  1  one-cycle pulse from interface: current command/read/change_size completed
- sd_error  input  1  interface error flag, sampled with cmd_done
- header_in  input  64  Header_data from interface
- image_in  input  24  Image_data from interface
- pix_ready  input  1  downstream accepts pixel
- cmd0, cmd8, acmd41, cmd2, cmd3, cmd7  output  1 each  command requests to interface
- change_size  output  1  block-size change request
- block_size  output  32  requested block size
- read  output  1  read request
- r_address  output  32  read byte address
- header_data  output  64  latched header
- header_valid  output  1  one-cycle pulse, header_data updated
- pixel_data  output  24  latched pixel
- pixel_valid  output  1  pixel_data valid until accepted
- init_done  output  1  high from CMD7 completion until restart/reset
- seq_done  output  1  high in DONE
- seq_error  output  1  high in ERROR

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE; all outputs 0; counters 0.
  - Takes effect mid-sequence immediately; pending requests drop the same cycle.
- States: IDLE, CMD0, CMD8, ACMD41, CMD2, CMD3, CMD7, SET_HDR, RD_HDR, SET_PIX, RD_PIX, PIX_OUT, DONE, ERROR.
- Outputs are decoded from the state register (Moore). Exactly one of cmd0/cmd8/acmd41/cmd2/cmd3/cmd7/change_size/read is high in the matching state and held until cmd_done.
- IDLE/DONE/ERROR: start=1 -> CMD0 next cycle. In DONE or ERROR this also clears init_done, the retry count and the pixel count.
- Command advance: a cmd_done=1, sd_error=0 cycle moves to the next state on the following edge.
  - Order: CMD0 -> CMD8 -> ACMD41 -> CMD2 -> CMD3 -> CMD7 -> SET_HDR.
  - init_done is set on leaving CMD7.
- Errors and retries:
  - cmd_done=1 with sd_error=1 -> ERROR, except in ACMD41.
  - In ACMD41 it increments the retry count and stays in ACMD41. acmd41 deasserts for exactly one cycle, then reasserts.
  - When the retry count reaches ACMD41_RETRIES -> ERROR.
  - Simultaneous cmd_done and sd_error: error handling wins.
- detect=0 in any state other than IDLE/DONE/ERROR -> ERROR next cycle. Takes priority over cmd_done.
- SET_HDR: change_size=1, block_size=HEADER_BYTES. cmd_done -> RD_HDR.
- RD_HDR:
  - read=1, r_address=BASE_ADDR, block_size still HEADER_BYTES.
  - On cmd_done: header_data<=header_in, header_valid=1 for one cycle, -> SET_PIX.
- SET_PIX: change_size=1, block_size=PIXEL_BYTES. cmd_done -> RD_PIX.
- RD_PIX:
  - read=1, r_address = BASE_ADDR + HEADER_BYTES + PIXEL_BYTES*pixel_count (32-bit wrap).
  - On cmd_done: pixel_data<=image_in, -> PIX_OUT.
- PIX_OUT:
  - pixel_valid=1; pixel_data stable while pix_ready=0.
  - On pix_ready=1: pixel_count++. If the new count = NUM_PIXELS -> DONE, else -> RD_PIX.
- block_size:
  - 0 in IDLE and CMD0..CMD7.
  - HEADER_BYTES in SET_HDR/RD_HDR.
  - PIXEL_BYTES in SET_PIX/RD_PIX/PIX_OUT/DONE.
- r_address is 0 outside RD_HDR/RD_PIX.
- cmd_done outside a request state is ignored.
- start outside IDLE/DONE/ERROR is ignored.

Test Plan:
- Reset, start=1 for 1 cycle, cmd_done pulse 3 cycles after each request -> cmd0..cmd7 each asserted in order and held until their pulse; init_done=1 after CMD7; change_size=1 with block_size=54.
- Header read with header_in=64'h0000_0040_0000_0040 -> header_valid one cycle with that value; then change_size with block_size=3; first read r_address=54.
- 16 pixels, image_in=index, pix_ready=1 -> r_address 54,57,...,99; pixel_data 0..15; seq_done=1 after 16th accept.
- pix_ready=0 for 5 cycles on pixel 2 -> pixel_valid and pixel_data held; no read issued; r_address resumes at 63.
- sd_error with cmd_done in ACMD41 7 times, then clean -> proceeds to CMD2. With 8 errors -> seq_error=1.
- detect=0 during RD_PIX, then reset mid-CMD3 -> ERROR next cycle; after reset all outputs 0, state IDLE; start restarts at CMD0.
